// File: rtl/oclib_bc_csr_bridge_pkg.sv
// Shared types and constants for the byte-channel to CSR bridge.
//   bc_8b_s / bc_8b_fb_s : 8-bit ready/valid byte channel (forward / backpressure)
//   csr_s / csr_fb_s     : CSR request and response buses
//   CsrStatus*           : bit positions inside the status byte
//   Csr*FrameBytes       : total request frame lengths, including byte0
//   bc_csr_state_e       : bridge FSM states
package oclib_bc_csr_bridge_pkg;

  typedef struct packed {
    logic [7:0] data;
    logic       valid;
  } bc_8b_s;

  typedef struct packed {
    logic ready;
  } bc_8b_fb_s;

  typedef struct packed {
    logic        read;
    logic        write;
    logic [31:0] block;
    logic [31:0] address;
    logic [31:0] wdata;
  } csr_s;

  typedef struct packed {
    logic [31:0] rdata;
    logic        ready;
    logic        error;
  } csr_fb_s;

  localparam int CsrStatusCsrError   = 0;
  localparam int CsrStatusCsrTimeout = 1;
  localparam int CsrStatusBadCmd     = 2;
  localparam int CsrStatusRxTimeout  = 3;

  localparam int CsrReadFrameBytes  = 9;
  localparam int CsrWriteFrameBytes = 13;

  localparam logic [3:0] CmdRead   = 4'h1;
  localparam logic [3:0] CmdWrite  = 4'h2;
  localparam logic [3:0] CmdStatus = 4'he;
  localparam logic [3:0] CmdClear  = 4'hf;

  typedef enum logic [1:0] {
    BcCsrIdle,
    BcCsrRxArgs,
    BcCsrCsrReq,
    BcCsrTxResp
  } bc_csr_state_e;

  // Index of the final argument byte (byte0 is not counted by the arg counter).
  function automatic logic [3:0] args_last(input logic is_write);
    return is_write ? 4'(CsrWriteFrameBytes - 2) : 4'(CsrReadFrameBytes - 2);
  endfunction

endpackage

// File: rtl/oclib_bc_shift_out.sv
// Response serializer: loads up to 5 bytes (MSB first) plus a byte count and
// presents them one at a time on a ready/valid byte channel.
//   clock, resetn : clock and asynchronous active-low reset
//   load          : capture load_data/load_count (only issued while idle)
//   load_data     : response bytes, first byte in [39:32]
//   load_count    : number of bytes to send (1..5)
//   bcOut         : outgoing byte stream, data held until accepted
//   bcOutFb       : backpressure from the consumer
//   done          : pulses in the cycle the last byte is accepted
module oclib_bc_shift_out
  import oclib_bc_csr_bridge_pkg::*;
(
  input  logic        clock,
  input  logic        resetn,
  input  logic        load,
  input  logic [39:0] load_data,
  input  logic [2:0]  load_count,
  output bc_8b_s      bcOut,
  input  bc_8b_fb_s   bcOutFb,
  output logic        done
);

  logic [39:0] data_q, data_d;
  logic [2:0]  count_q, count_d;
  logic        valid_q, valid_d;
  logic        take;

  assign take = valid_q && bcOutFb.ready;

  // Shift one byte out per accepted transfer; the register only moves on
  // acceptance so data stays stable under backpressure.
  always_comb begin
    data_d  = data_q;
    count_d = count_q;
    valid_d = valid_q;
    done    = 1'b0;
    if (take) begin
      data_d  = {data_q[31:0], 8'h00};
      count_d = count_q - 3'd1;
      if (count_q == 3'd1) begin
        valid_d = 1'b0;
        done    = 1'b1;
      end
    end
    if (load) begin
      data_d  = load_data;
      count_d = load_count;
      valid_d = (load_count != 3'd0);
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      data_q  <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  assign bcOut.data  = data_q[39:32];
  assign bcOut.valid = valid_q;

endmodule

// File: rtl/oclib_bc_csr_bridge.sv
// Byte-channel to CSR bridge: parses request frames arriving on an 8-bit
// ready/valid stream, issues one CSR read/write at a time and streams back a
// status byte (plus read data for reads).
//   clock, resetn : clock and asynchronous active-low reset
//   bcIn/bcInFb   : request bytes and their backpressure
//   bcOut/bcOutFb : response bytes and their backpressure
//   csr/csrFb     : CSR request bus and its response
module oclib_bc_csr_bridge
  import oclib_bc_csr_bridge_pkg::*;
#(
  parameter int CsrTimeoutCycles = 1024,
  parameter int RxIdleCycles     = 65535
) (
  input  logic      clock,
  input  logic      resetn,
  input  bc_8b_s    bcIn,
  output bc_8b_fb_s bcInFb,
  output bc_8b_s    bcOut,
  input  bc_8b_fb_s bcOutFb,
  output csr_s      csr,
  input  csr_fb_s   csrFb
);

  bc_csr_state_e state_q, state_d;
  logic [31:0]   timer_q, timer_d;
  logic [3:0]    byte_cnt_q, byte_cnt_d;
  logic          is_write_q, is_write_d;
  logic [87:0]   args_q, args_d;
  csr_s          csr_q, csr_d;
  logic [7:0]    sticky_q, sticky_d;
  logic          ready_en_q;

  logic          in_ready, in_fire;
  logic [3:0]    byte0_space, byte0_cmd;
  logic          cmd_rw;
  logic [95:0]   args_next;
  logic          args_last_hit;
  logic          csr_seen, csr_expired, rx_expired;
  logic          load;
  logic [39:0]   load_data;
  logic [2:0]    load_count;
  logic [7:0]    op_status;
  logic          shift_done;

  // ready_en_q keeps bcInFb.ready low while reset is asserted even though the
  // FSM already sits in Idle.
  assign in_ready      = ready_en_q && ((state_q == BcCsrIdle) || (state_q == BcCsrRxArgs));
  assign in_fire       = bcIn.valid && in_ready;
  assign byte0_space   = bcIn.data[7:4];
  assign byte0_cmd     = bcIn.data[3:0];
  assign cmd_rw        = (byte0_space == 4'h0) && ((byte0_cmd == CmdRead) || (byte0_cmd == CmdWrite));
  assign args_next     = {args_q, bcIn.data};
  assign args_last_hit = (byte_cnt_q == args_last(is_write_q));
  assign csr_seen      = csrFb.ready || csrFb.error;
  assign csr_expired   = (timer_q == 32'(CsrTimeoutCycles - 1));
  assign rx_expired    = (RxIdleCycles != 0) && (timer_q == 32'(RxIdleCycles));

  // State register and all datapath flops.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= BcCsrIdle;
      timer_q    <= '0;
      byte_cnt_q <= '0;
      is_write_q <= 1'b0;
      args_q     <= '0;
      csr_q      <= '0;
      sticky_q   <= '0;
      ready_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      byte_cnt_q <= byte_cnt_d;
      is_write_q <= is_write_d;
      args_q     <= args_d;
      csr_q      <= csr_d;
      sticky_q   <= sticky_d;
      ready_en_q <= 1'b1;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      BcCsrIdle: begin
        if (in_fire) state_d = cmd_rw ? BcCsrRxArgs : BcCsrTxResp;
      end
      BcCsrRxArgs: begin
        if (in_fire) begin
          if (args_last_hit) state_d = BcCsrCsrReq;
        end else if (rx_expired) begin
          state_d = BcCsrIdle;
        end
      end
      BcCsrCsrReq: begin
        if (csr_seen || csr_expired) state_d = BcCsrTxResp;
      end
      BcCsrTxResp: begin
        if (shift_done) state_d = BcCsrIdle;
      end
      default: state_d = BcCsrIdle;
    endcase
  end

  // Datapath and response loading. The single timer serves as the inter-byte
  // gap counter in RxArgs and the CSR wait counter in CsrReq; it restarts on
  // every state change and every accepted argument byte.
  always_comb begin
    timer_d    = '0;
    byte_cnt_d = byte_cnt_q;
    is_write_d = is_write_q;
    args_d     = args_q;
    csr_d      = csr_q;
    sticky_d   = sticky_q;
    load       = 1'b0;
    load_data  = '0;
    load_count = '0;
    op_status  = '0;
    case (state_q)
      BcCsrIdle: begin
        byte_cnt_d = '0;
        if (in_fire) begin
          is_write_d = (byte0_cmd == CmdWrite);
          args_d     = '0;
          if (!cmd_rw) begin
            load       = 1'b1;
            load_count = 3'd1;
            if ((byte0_space == 4'h0) && (byte0_cmd == CmdStatus)) begin
              load_data = {sticky_q, 32'h0};
            end else if ((byte0_space == 4'h0) && (byte0_cmd == CmdClear)) begin
              sticky_d = '0;
            end else begin
              op_status[CsrStatusBadCmd] = 1'b1;
              sticky_d  = sticky_q | op_status;
              load_data = {op_status, 32'h0};
            end
          end
        end
      end
      BcCsrRxArgs: begin
        if (in_fire) begin
          args_d     = args_next[87:0];
          byte_cnt_d = byte_cnt_q + 4'd1;
          if (args_last_hit) begin
            csr_d.read  = !is_write_q;
            csr_d.write = is_write_q;
            if (is_write_q) begin
              csr_d.block   = args_next[95:64];
              csr_d.address = args_next[63:32];
              csr_d.wdata   = args_next[31:0];
            end else begin
              csr_d.block   = args_next[63:32];
              csr_d.address = args_next[31:0];
              csr_d.wdata   = '0;
            end
          end
        end else if (rx_expired) begin
          sticky_d[CsrStatusRxTimeout] = 1'b1;
        end else if (RxIdleCycles != 0) begin
          timer_d = timer_q + 32'd1;
        end
      end
      BcCsrCsrReq: begin
        timer_d = timer_q + 32'd1;
        if (csr_seen || csr_expired) begin
          csr_d = '0;
          // error outranks ready when both arrive together
          if (csrFb.error) op_status[CsrStatusCsrError] = 1'b1;
          else if (!csrFb.ready) op_status[CsrStatusCsrTimeout] = 1'b1;
          sticky_d = sticky_q | op_status;
          load     = 1'b1;
          if (is_write_q) begin
            load_data  = {op_status, 32'h0};
            load_count = 3'd1;
          end else begin
            load_data  = {op_status, (csrFb.ready && !csrFb.error) ? csrFb.rdata : 32'h0};
            load_count = 3'd5;
          end
        end
      end
      default: ;
    endcase
  end

  // Outputs.
  always_comb begin
    bcInFb.ready = in_ready;
    csr          = csr_q;
  end

  oclib_bc_shift_out u_shift_out (
    .clock      (clock),
    .resetn     (resetn),
    .load       (load),
    .load_data  (load_data),
    .load_count (load_count),
    .bcOut      (bcOut),
    .bcOutFb    (bcOutFb),
    .done       (shift_done)
  );

endmodule
